// File: rtl/alu_arbiter.sv
// Two-requester arbiter for a shared multi-cycle ALU, one command in flight.
// Define ALU_ARB_OPCHK_EN to answer opcodes 1101-1111 with rsp_err instead of running them.
module alu_arbiter #(
    parameter int W       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_cnt,
    input  logic [W-1:0] alu_d,
    input  logic         alu_carry,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_d,
    output logic         rsp_carry,
    output logic         rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] LAST = 2'(ALU_LAT - 1);

    state_t       state;
    logic         prio;
    logic [1:0]   cnt;
    logic         gnt;
    logic         accept;
    logic         skip;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [3:0]   sel_op;

    always_comb begin
        gnt        = (req0_valid & req1_valid) ? prio : req1_valid;
        accept     = (state == IDLE) & ~rst & (req0_valid | req1_valid);
        req0_ready = accept & ~gnt;
        req1_ready = accept & gnt;
        sel_a      = gnt ? req1_a : req0_a;
        sel_b      = gnt ? req1_b : req0_b;
        sel_op     = gnt ? req1_op : req0_op;
    end

`ifdef ALU_ARB_OPCHK_EN
    assign skip = (sel_op > 4'd12);
`else
    assign skip = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_d     <= '0;
            rsp_carry <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id <= gnt;
                        cnt    <= '0;
`ifdef ALU_ARB_OPCHK_EN
                        rsp_err <= skip;
`endif
                        // Illegal opcodes bypass the ALU and leave its operands untouched
                        if (skip) begin
                            rsp_valid <= 1'b1;
                            rsp_d     <= '0;
                            rsp_carry <= 1'b0;
                            state     <= RESP;
                        end else begin
                            alu_a   <= sel_a;
                            alu_b   <= sel_b;
                            alu_cnt <= sel_op;
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == LAST) begin
                        rsp_d     <= alu_d;
                        rsp_carry <= (alu_cnt == 4'd0) & alu_carry;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        prio      <= ~rsp_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU_LAT=1 instance plus an ALU_LAT=3 instance.
// Both share stimulus; each has its own behavioural ALU.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_op, req1_op;
    logic         rsp_ready;

    logic         req0_ready, req1_ready;
    logic [W-1:0] alu_a, alu_b, alu_d, rsp_d;
    logic [3:0]   alu_cnt;
    logic         alu_carry, rsp_valid, rsp_id, rsp_carry, rsp_err;

    logic         l3_req0_ready, l3_req1_ready;
    logic [W-1:0] l3_alu_a, l3_alu_b, l3_alu_d, l3_rsp_d;
    logic [3:0]   l3_alu_cnt;
    logic         l3_alu_carry, l3_rsp_valid, l3_rsp_id, l3_rsp_carry, l3_rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Opcode map: 0 add, 1 sub, 6 and, 7 or, 8 xor, 12 srl, others ~a.
    // Carry is forced high for non-add ops so masking is observable.
    function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] c);
        case (c)
            4'd0:    alu_fn = {1'b0, a} + {1'b0, b};
            4'd1:    alu_fn = {1'b1, a - b};
            4'd6:    alu_fn = {1'b1, a & b};
            4'd7:    alu_fn = {1'b1, a | b};
            4'd8:    alu_fn = {1'b1, a ^ b};
            4'd12:   alu_fn = {1'b1, a >> b[4:0]};
            default: alu_fn = {1'b1, ~a};
        endcase
    endfunction

    always_comb {alu_carry, alu_d} = alu_fn(alu_a, alu_b, alu_cnt);
    always_comb {l3_alu_carry, l3_alu_d} = alu_fn(l3_alu_a, l3_alu_b, l3_alu_cnt);

    alu_arbiter #(.W(W), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cnt(alu_cnt),
        .alu_d(alu_d), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_d(rsp_d), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    alu_arbiter #(.W(W), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(l3_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(l3_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_cnt(l3_alu_cnt),
        .alu_d(l3_alu_d), .alu_carry(l3_alu_carry),
        .rsp_valid(l3_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(l3_rsp_id), .rsp_d(l3_rsp_d), .rsp_carry(l3_rsp_carry), .rsp_err(l3_rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        tick();
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_d", rsp_d, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_cnt", alu_cnt, 0);

        // add with carry out, single requester
        req0_valid = 1'b1; req0_op = 4'd0;
        req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001;
        rsp_ready = 1'b1;
        #1;
        chk("add_rdy0", req0_ready, 1);
        chk("add_rdy1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("add_exec_valid", rsp_valid, 0);
        chk("add_alu_a", alu_a, 32'hFFFF_FFFF);
        tick();
        chk("add_valid", rsp_valid, 1);
        chk("add_d", rsp_d, 32'h0);
        chk("add_carry", rsp_carry, 1);
        chk("add_id", rsp_id, 0);
        tick();
        chk("add_idle", rsp_valid, 0);

        // simultaneous requests after reset: req0 first
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd6;
        req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00;
        req1_valid = 1'b1; req1_op = 4'd8;
        req1_a = 32'h0000_FFFF; req1_b = 32'hFFFF_FFFF;
        #1;
        chk("arb_rdy0", req0_ready, 1);
        chk("arb_rdy1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("arb_exec_rdy1", req1_ready, 0);
        tick();
        chk("arb1_valid", rsp_valid, 1);
        chk("arb1_id", rsp_id, 0);
        chk("arb1_d", rsp_d, 32'hF000_F000);
        chk("arb1_carry", rsp_carry, 0);
        tick();
        chk("arb2_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("arb2_valid", rsp_valid, 1);
        chk("arb2_id", rsp_id, 1);
        chk("arb2_d", rsp_d, 32'hFFFF_0000);
        chk("arb2_carry", rsp_carry, 0);
        tick();

        // round robin with both held valid
        req0_valid = 1'b1; req0_op = 4'd12;
        req0_a = 32'h8000_0000; req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 4'd0;
        req1_a = 32'h7FFF_FFFF; req1_b = 32'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_rdy0", req0_ready, (i % 2 == 0));
            chk("rr_rdy1", req1_ready, (i % 2 == 1));
            tick();
            chk("rr_busy", {req0_ready, req1_ready}, 0);
            tick();
            chk("rr_valid", rsp_valid, 1);
            chk("rr_id", rsp_id, i % 2);
            chk("rr_d", rsp_d, (i % 2 == 1) ? 32'h8000_0000 : 32'h0800_0000);
            chk("rr_carry", rsp_carry, 0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // consumer stall in RESP
        req0_valid = 1'b1; req0_op = 4'd7;
        req0_a = 32'h1234_0000; req0_b = 32'h0000_5678;
        rsp_ready = 1'b0;
        #1;
        chk("st_rdy0", req0_ready, 1);
        tick();
        req1_valid = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("st_valid", rsp_valid, 1);
            chk("st_d", rsp_d, 32'h1234_5678);
            chk("st_id", rsp_id, 0);
            chk("st_rdy", {req0_ready, req1_ready}, 0);
            tick();
        end
        rsp_ready = 1'b1;
        chk("st_hs_valid", rsp_valid, 1);
        tick();
        chk("st_idle_valid", rsp_valid, 0);
        chk("st_prio_rdy1", req1_ready, 1);
        chk("st_prio_rdy0", req0_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("drop_rdy", {req0_ready, req1_ready}, 0);
        tick();
        tick();
        chk("drop_no_rsp", rsp_valid, 0);

        // opcode 1110 from req1
        req1_valid = 1'b1; req1_op = 4'd14;
        req1_a = 32'h0000_FFFF; req1_b = 32'h0;
        #1;
        chk("op_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
`ifdef ALU_ARB_OPCHK_EN
        chk("opchk_valid", rsp_valid, 1);
        chk("opchk_err", rsp_err, 1);
        chk("opchk_d", rsp_d, 0);
        chk("opchk_carry", rsp_carry, 0);
        chk("opchk_alu_cnt", alu_cnt, 4'd7);
        chk("opchk_alu_a", alu_a, 32'h1234_0000);
        tick();
`else
        chk("op_exec_valid", rsp_valid, 0);
        tick();
        chk("op_valid", rsp_valid, 1);
        chk("op_err", rsp_err, 0);
        chk("op_d", rsp_d, 32'hFFFF_0000);
        chk("op_carry", rsp_carry, 0);
        tick();
`endif

        // reset mid-EXEC on the ALU_LAT=3 instance
        do_reset();
        req1_valid = 1'b1; req1_op = 4'd1;
        req1_a = 32'd5; req1_b = 32'd3;
        #1;
        chk("l3_acc_rdy1", l3_req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("l3_rst_alu_a", l3_alu_a, 0);
        for (int k = 0; k < 4; k++) begin
            chk("l3_no_rsp", l3_rsp_valid, 0);
            tick();
        end
        req0_valid = 1'b1; req0_op = 4'd0;
        req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 4'd8;
        #1;
        chk("l3_rdy0", l3_req0_ready, 1);
        chk("l3_rdy1", l3_req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("l3_lat", l3_rsp_valid, 0);
            tick();
        end
        chk("l3_valid", l3_rsp_valid, 1);
        chk("l3_id", l3_rsp_id, 0);
        chk("l3_d", l3_rsp_d, 32'd3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
